// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch sequencer: FSM state codes and
// instruction geometry.
package fetch_pkg;

  localparam logic [1:0] S_ISSUE = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam int BYTES_PER_INST = 4;
  localparam int INST_W         = 32;
  localparam int PC_STEP        = 4;

endpackage

// File: rtl/inst_assembler.sv
// Shifts returning memory bytes in MSB-first; word_next is the big-endian word
// formed by the three held bytes plus the byte currently on byte_in.
module inst_assembler
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [INST_W-1:0] word_next
);

  // Only three bytes are stored; the fourth is taken live from byte_in.
  logic [INST_W-9:0] shreg;

  assign word_next = {shreg, byte_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (clr) begin
      shreg <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[INST_W-17:0], byte_in};
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: four byte reads per instruction, big-endian
// assembly, valid/ready hand-off to decode. FETCH_MISALIGN_TRAP_EN enables the
// misaligned-redirect FAULT state.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              fault,
  output logic [1:0]        dbg_state
);

  // Handshake: inst is transferred on a rising edge where inst_valid and
  // inst_ready are both 1; inst/inst_pc do not change while inst_valid=1 and
  // inst_ready=0. A redirect on that same edge overrides the handshake.

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic [31:0]       pc;
  logic              pending;
  logic              redir_bad;
  logic              go;
  logic              issue;
  logic [31:0]       pc_eff;
  logic [1:0]        cnt_eff;
  logic [INST_W-1:0] word_next;

  assign dbg_state = state;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redir_bad = 1'b0;
`endif

  // A restart (redirect or accepted instruction) issues byte 0 on the same edge.
  always_comb begin
    go      = 1'b0;
    pc_eff  = pc;
    cnt_eff = cnt;
    if (redirect_valid) begin
      if (!redir_bad) begin
        go      = 1'b1;
        pc_eff  = redirect_pc;
        cnt_eff = 2'd0;
      end
    end else if (state == S_HOLD && inst_ready) begin
      go      = 1'b1;
      pc_eff  = pc + 32'(PC_STEP);
      cnt_eff = 2'd0;
    end
    issue = go || (state == S_ISSUE && !redirect_valid);
  end

  inst_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (redirect_valid),
    .shift_en  (pending),
    .byte_in   (mem_rdata),
    .word_next (word_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_ISSUE;
      cnt        <= 2'd0;
      pc         <= RESET_PC;
      pending    <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      fault      <= 1'b0;
    end else begin
      // A read issued before a redirect returns its byte next cycle; drop it.
      pending <= mem_rd && !redirect_valid;
      mem_rd  <= issue;
      if (issue) begin
        mem_addr <= pc_eff[ADDR_W-1:0] + ADDR_W'(cnt_eff);
        pc       <= pc_eff;
        cnt      <= cnt_eff + 2'd1;
        state    <= (cnt_eff == 2'(BYTES_PER_INST - 1)) ? S_DRAIN : S_ISSUE;
      end
      if (redirect_valid) begin
        inst_valid <= 1'b0;
        fault      <= redir_bad;
        if (redir_bad) begin
          state <= S_FAULT;
          cnt   <= 2'd0;
        end
      end else begin
        case (state)
          S_DRAIN: begin
            if (cnt == 2'd1) begin
              inst       <= word_next;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              state      <= S_HOLD;
              cnt        <= 2'd0;
            end else begin
              cnt <= 2'd1;
            end
          end
          S_HOLD: begin
            if (inst_ready) inst_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random
// redirects/back-pressure against a cycle-count reference model.
module tb_fetch_sequencer;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault;
  logic [1:0]  dbg_state;

  fetch_sequencer #(.ADDR_W(8), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fault          (fault),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_k counts edges since the current fetch started: bytes requested for
  // k=0..3, nothing at k=4, instruction presented from k=5 on.
  logic [31:0] m_pc;
  int          m_k;
  bit          m_fault;

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [7:0] a;
    a = pc[7:0];
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  task automatic model_edge(input logic rv, input logic [31:0] rpc, input logic rdy);
    bit v_before;
    v_before = !m_fault && m_k >= 5;
    if (rv) begin
      if (TRAP && rpc[1:0] != 2'b00) begin
        m_fault = 1'b1;
      end else begin
        m_fault = 1'b0;
        m_pc    = rpc;
        m_k     = 0;
      end
    end else if (v_before && rdy) begin
      exp_q.push_back(exp_word(m_pc));
      m_pc = m_pc + 32'd4;
      m_k  = 0;
    end else if (m_k < 1000) begin
      m_k++;
    end
  endtask

  task automatic compare();
    bit rd_e, val_e;
    rd_e  = !m_fault && m_k >= 0 && m_k <= 3;
    val_e = !m_fault && m_k >= 5;
    check("mem_rd", 32'(mem_rd), 32'(rd_e));
    if (rd_e) check("mem_addr", 32'(mem_addr), 32'((m_pc + 32'(m_k)) & 32'hFF));
    check("inst_valid", 32'(inst_valid), 32'(val_e));
    if (val_e) begin
      check("inst", inst, exp_word(m_pc));
      check("inst_pc", inst_pc, m_pc);
    end
    check("fault", 32'(fault), 32'(m_fault));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    if (inst_valid && rdy && !rv) got_q.push_back(inst);
    @(posedge clk);
    model_edge(rv, rpc, rdy);
    #1;
    compare();
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, rdy);
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    m_pc    = 32'h0;
    m_k     = -1;
    m_fault = 1'b0;
    @(posedge clk);
    #1;
    // The edge just passed was the first after release: the model's t0.
    m_k = 0;
    compare();
  endtask

  task automatic wait_k(input string tag, input int k);
    for (int i = 0; i < 40 && !(m_k == k && !m_fault); i++) run(1, 1'b0);
    if (!(m_k == k && !m_fault)) check(tag, 32'(m_k), 32'(k));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rpc;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;
    repeat (2) @(posedge clk);

    // Basic fetch from RESET_PC with inst_ready held high.
    do_reset();
    run(5, 1'b1);
    check("first_inst", inst, 32'h8C010004);
    check("first_inst_pc", inst_pc, 32'h0);
    run(1, 1'b1);
    check("next_addr", 32'(mem_addr), 32'h4);

    // Back-pressure in HOLD, then accept.
    wait_k("wait_hold", 5);
    run(10, 1'b0);
    run(2, 1'b1);

    // Redirect mid-fetch at t2.
    wait_k("wait_t2", 2);
    step(1'b1, 32'h40, 1'b1);
    check("redir_addr", 32'(mem_addr), 32'h40);
    run(6, 1'b1);

    // Redirect near the top of the byte space: address wraps.
    step(1'b1, 32'hFE, 1'b0);
    run(7, 1'b0);
    check("wrap_inst_pc", inst_pc, 32'hFE);

    // Misaligned redirect, then an aligned one.
    step(1'b1, 32'h41, 1'b0);
    run(4, 1'b0);
    step(1'b1, 32'h44, 1'b0);
    run(7, 1'b1);

    // Redirect coincident with a handshake.
    wait_k("wait_hs", 5);
    step(1'b1, 32'h80, 1'b1);
    run(7, 1'b1);
    check("hs_redir_inst_pc", inst_pc, 32'h80);

    // Asynchronous reset in the middle of a fetch.
    run(2, 1'b1);
    do_reset();
    run(6, 1'b1);

    // Random redirects and back-pressure.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 2))
          0:       rpc = {24'h0, 8'($urandom_range(0, 63) * 4)};
          1:       rpc = 32'($urandom_range(0, 255));
          default: rpc = $urandom;
        endcase
        step(1'b1, rpc, 1'($urandom_range(0, 1)));
      end else begin
        step(1'b0, 32'h0, 1'($urandom_range(0, 9) < 7));
      end
    end

    // Accepted-instruction stream.
    check("accept_count", 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check("accepted_inst", got_q.pop_front(), exp_q.pop_front());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
